// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for both sides of the dual-clock FIFO.
// Gray conversions are written for any width up to GRAY_MAX_W.
package cdc_fifo_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(
      input logic [GRAY_MAX_W-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs make the prefix XOR width-independent.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(
      input logic [GRAY_MAX_W-1:0] g
   );
      logic [GRAY_MAX_W-1:0] b;
      b = '0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/cdc_fifo_reader_if.sv
// Consumer-facing valid/ready word stream of the FIFO read side.
interface cdc_fifo_reader_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic                  r_valid;
   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_data;

   modport master (
      output r_valid,
      output r_data,
      input  r_ready
   );

   modport slave (
      input  r_valid,
      input  r_data,
      output r_ready
   );

endinterface

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for Gray-coded pointers crossing clock domains.
module cdc_sync2 #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/cdc_fifo_reader.sv
// Read-side controller of the dual-clock FIFO: pointer sync,
// read pointer and a first-word-fall-through output register.
module cdc_fifo_reader
   import cdc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_SIZE  = 4
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic [ADDR_SIZE:0]    r_w_ptr_gray,
   output logic [ADDR_SIZE:0]    r_ptr_gray,
   output logic [ADDR_SIZE-1:0]  mem_r_addr,
   input  logic [DATA_WIDTH-1:0] mem_r_data,
   output logic                  r_empty,
   output logic [ADDR_SIZE:0]    r_count,
   cdc_fifo_reader_if.master     r_out
);

   localparam int PW = ADDR_SIZE + 1;

   logic [PW-1:0]         w_gray_s2;
   logic [PW-1:0]         w_bin_sync;
   logic [PW-1:0]         r_bin_q, r_bin_d;
   logic [PW-1:0]         r_gray_q, r_gray_d;
   logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
   out_state_e            state_q, state_d;
   logic                  mem_empty;
   logic                  load;

   cdc_sync2 #(
      .WIDTH(PW)
   ) u_w_sync (
      .clk (r_clk),
      .rst (r_rst),
      .d_i (r_w_ptr_gray),
      .q_o (w_gray_s2)
   );

   assign w_bin_sync = PW'(gray2bin(GRAY_MAX_W'(w_gray_s2)));

   always_comb begin
      state_d   = state_q;
      r_bin_d   = r_bin_q;
      r_data_d  = r_data_q;
      mem_empty = (r_gray_q == w_gray_s2);
      load      = !mem_empty &&
                  ((state_q == OUT_EMPTY) || r_out.r_ready);
      // The memory slot is released as soon as it is copied out.
      if (load) begin
         r_bin_d  = r_bin_q + PW'(1);
         r_data_d = mem_r_data;
      end
      unique case (state_q)
         OUT_EMPTY: if (load) state_d = OUT_FULL;
         OUT_FULL:  if (r_out.r_ready && !load) state_d = OUT_EMPTY;
         default:   state_d = OUT_EMPTY;
      endcase
      r_gray_d = PW'(bin2gray(GRAY_MAX_W'(r_bin_d)));
   end

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         state_q  <= OUT_EMPTY;
         r_bin_q  <= '0;
         r_gray_q <= '0;
         r_data_q <= '0;
      end else begin
         state_q  <= state_d;
         r_bin_q  <= r_bin_d;
         r_gray_q <= r_gray_d;
         r_data_q <= r_data_d;
      end
   end

   assign r_out.r_valid = (state_q == OUT_FULL);
   assign r_out.r_data  = r_data_q;
   assign r_empty       = (state_q != OUT_FULL);
   assign r_ptr_gray    = r_gray_q;
   assign mem_r_addr    = r_bin_q[ADDR_SIZE-1:0];
   assign r_count       = w_bin_sync - r_bin_q;

endmodule

// File: tb/tb_cdc_fifo_reader.sv
// Directed bench for cdc_fifo_reader with a modelled memory and writer.
module tb_cdc_fifo_reader;

   logic       r_clk;
   logic       r_rst;
   logic [4:0] w_bin;
   logic [4:0] r_w_ptr_gray;
   logic [4:0] r_ptr_gray;
   logic [3:0] mem_r_addr;
   logic [7:0] mem_r_data;
   logic       r_empty;
   logic [4:0] r_count;
   logic [7:0] mem [16];

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   cdc_fifo_reader_if #(.DATA_WIDTH(8)) rif ();

   cdc_fifo_reader #(
      .DATA_WIDTH(8),
      .ADDR_SIZE (4)
   ) dut (
      .r_clk        (r_clk),
      .r_rst        (r_rst),
      .r_w_ptr_gray (r_w_ptr_gray),
      .r_ptr_gray   (r_ptr_gray),
      .mem_r_addr   (mem_r_addr),
      .mem_r_data   (mem_r_data),
      .r_empty      (r_empty),
      .r_count      (r_count),
      .r_out        (rif)
   );

   assign r_w_ptr_gray = w_bin ^ (w_bin >> 1);
   assign mem_r_data   = mem[mem_r_addr];

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " valid"}, 32'(rif.r_valid), 32'd0);
      chk({tag, " empty"}, 32'(r_empty), 32'd1);
      chk({tag, " data"}, 32'(rif.r_data), 32'd0);
      chk({tag, " gray"}, 32'(r_ptr_gray), 32'd0);
      chk({tag, " addr"}, 32'(mem_r_addr), 32'd0);
      chk({tag, " count"}, 32'(r_count), 32'd0);
   endtask

   task automatic do_reset();
      r_rst = 1'b1;
      w_bin = 5'd0;
      step();
      step();
      r_rst = 1'b0;
   endtask

   logic [7:0] wr;
   logic [7:0] rd;
   int first_c;
   int last_c;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      rif.r_ready = 1'b0;
      r_rst = 1'b1;
      w_bin = 5'b00010;

      // reset held three cycles with a nonzero write pointer
      for (int i = 0; i < 3; i++) begin
         step();
         chk_reset_vals("rst");
      end
      r_rst = 1'b0;
      w_bin = 5'd0;
      step();
      chk("rel count", 32'(r_count), 32'd0);
      chk("rel valid", 32'(rif.r_valid), 32'd0);

      // single word
      mem[0] = 8'hA5;
      w_bin = 5'd1;
      step();
      chk("sw k valid", 32'(rif.r_valid), 32'd0);
      chk("sw k count", 32'(r_count), 32'd0);
      step();
      chk("sw k1 valid", 32'(rif.r_valid), 32'd0);
      chk("sw k1 count", 32'(r_count), 32'd1);
      step();
      chk("sw valid", 32'(rif.r_valid), 32'd1);
      chk("sw data", 32'(rif.r_data), 32'hA5);
      chk("sw gray", 32'(r_ptr_gray), 32'b00001);
      chk("sw count", 32'(r_count), 32'd0);
      rif.r_ready = 1'b1;
      step();
      rif.r_ready = 1'b0;
      chk("sw pop valid", 32'(rif.r_valid), 32'd0);
      chk("sw pop empty", 32'(r_empty), 32'd1);

      // backpressure
      do_reset();
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      mem[2] = 8'h33;
      w_bin = 5'd3;
      step();
      step();
      step();
      chk("bp valid", 32'(rif.r_valid), 32'd1);
      chk("bp data", 32'(rif.r_data), 32'h11);
      chk("bp count", 32'(r_count), 32'd2);
      chk("bp gray", 32'(r_ptr_gray), 32'b00001);
      step();
      step();
      chk("bp hold data", 32'(rif.r_data), 32'h11);
      chk("bp hold gray", 32'(r_ptr_gray), 32'b00001);
      rif.r_ready = 1'b1;
      step();
      chk("bp w2 data", 32'(rif.r_data), 32'h22);
      chk("bp w2 count", 32'(r_count), 32'd1);
      step();
      chk("bp w3 data", 32'(rif.r_data), 32'h33);
      chk("bp w3 valid", 32'(rif.r_valid), 32'd1);
      step();
      chk("bp end valid", 32'(rif.r_valid), 32'd0);
      chk("bp end data", 32'(rif.r_data), 32'h33);
      rif.r_ready = 1'b0;

      // wrap: 40 words streamed at full rate
      do_reset();
      rif.r_ready = 1'b1;
      wr = 8'd0;
      rd = 8'd0;
      first_c = -1;
      last_c = -1;
      for (int c = 0; c < 200 && rd < 8'd40; c++) begin
         if (wr < 8'd40 && (wr - rd) < 8'd16) begin
            mem[wr[3:0]] = wr;
            wr = wr + 8'd1;
            w_bin = wr[4:0];
         end
         step();
         if (rif.r_valid) begin
            chk("wrap data", 32'(rif.r_data), 32'(rd));
            if (rd == 8'd15)
               chk("wrap gray16", 32'(r_ptr_gray), 32'b11000);
            if (rd == 8'd31)
               chk("wrap gray32", 32'(r_ptr_gray), 32'd0);
            if (first_c < 0) first_c = c;
            last_c = c;
            rd = rd + 8'd1;
         end
      end
      chk("wrap received", 32'(rd), 32'd40);
      chk("wrap no bubble", 32'(last_c - first_c), 32'd39);
      rif.r_ready = 1'b0;

      // full: writer a whole DEPTH ahead
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
      w_bin = 5'd16;
      step();
      chk("full k count", 32'(r_count), 32'd0);
      step();
      chk("full count", 32'(r_count), 32'd16);
      chk("full pre valid", 32'(rif.r_valid), 32'd0);
      step();
      chk("full load count", 32'(r_count), 32'd15);
      chk("full load valid", 32'(rif.r_valid), 32'd1);
      chk("full load data", 32'(rif.r_data), 32'h40);

      // reset while a pop and a load would both fire
      rif.r_ready = 1'b1;
      r_rst = 1'b1;
      step();
      chk_reset_vals("midrst");
      r_rst = 1'b0;
      rif.r_ready = 1'b0;
      w_bin = 5'd0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
